lane_pause_req_ctrl: RTL



---
 rtl/lane_pause_req_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/lane_pause_req_ctrl.sv
// Lane pause request controller: round-robin arbitration of delay-update requests
// and the pause / load-strobe / release / acknowledge / gap sequence for the PHY lane.
module lane_pause_req_ctrl #(
   parameter int NUM_REQ     = 4,
   parameter int PRE_CYCLES  = 2,
   parameter int POST_CYCLES = 3,
   parameter int MIN_GAP     = 4
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [NUM_REQ-1:0] REQ,
   input  logic               HOLD_OFF,
   output logic               HS_IO_CLK_PAUSE,
   output logic               LOAD_STB,
   output logic [NUM_REQ-1:0] LOAD_SEL,
   output logic [NUM_REQ-1:0] ACK,
   output logic               BUSY
);

   localparam int MAX_PP = (PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES;
   localparam int MAX_C  = (MAX_PP > MIN_GAP) ? MAX_PP : MIN_GAP;
   localparam int CNT_W  = $clog2(MAX_C + 1);
   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_LOAD = 3'd2,
      ST_POST = 3'd3,
      ST_GAP  = 3'd4
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [PTR_W-1:0]   r_ptr;
   logic [NUM_REQ-1:0] r_grant;
   logic               r_pause;
   logic               r_load_stb;
   logic [NUM_REQ-1:0] r_ack;

   state_t             w_nxt_state;
   logic [CNT_W-1:0]   w_nxt_cnt;
   logic [PTR_W-1:0]   w_nxt_ptr;
   logic [NUM_REQ-1:0] w_nxt_grant;
   logic [NUM_REQ-1:0] w_nxt_ack;
   logic               w_nxt_pause;
   logic               w_nxt_load_stb;
   logic               w_found;
   logic [PTR_W-1:0]   w_gidx;
   logic               w_cnt_last;

   // Round-robin search: first set request at or after the pointer, wrapping.
   always_comb begin : arb
      int idx;
      idx     = 0;
      w_found = 1'b0;
      w_gidx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(r_ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!w_found && REQ[idx]) begin
            w_found = 1'b1;
            w_gidx  = PTR_W'(idx);
         end
      end
   end

   assign w_cnt_last = (r_cnt == CNT_W'(1));

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_ptr   = r_ptr;
      w_nxt_grant = r_grant;
      w_nxt_ack   = '0;
      case (r_state)
         ST_IDLE: begin
            if (!HOLD_OFF && w_found) begin
               w_nxt_state = ST_PRE;
               w_nxt_cnt   = CNT_W'(PRE_CYCLES);
               w_nxt_grant = NUM_REQ'(1) << w_gidx;
               w_nxt_ptr   = (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + PTR_W'(1);
            end
         end
         ST_PRE: begin
            if (w_cnt_last) begin
               w_nxt_state = ST_LOAD;
               w_nxt_cnt   = '0;
            end else begin
               w_nxt_cnt = r_cnt - CNT_W'(1);
            end
         end
         ST_LOAD: begin
            w_nxt_state = ST_POST;
            w_nxt_cnt   = CNT_W'(POST_CYCLES);
         end
         ST_POST: begin
            if (w_cnt_last) begin
               w_nxt_state = ST_GAP;
               w_nxt_cnt   = CNT_W'(MIN_GAP);
               w_nxt_ack   = r_grant;
            end else begin
               w_nxt_cnt = r_cnt - CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (w_cnt_last) begin
               w_nxt_state = ST_IDLE;
               w_nxt_cnt   = '0;
               w_nxt_grant = '0;
            end else begin
               w_nxt_cnt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = '0;
            w_nxt_grant = '0;
         end
      endcase
      w_nxt_pause    = (w_nxt_state == ST_PRE) || (w_nxt_state == ST_LOAD) ||
                       (w_nxt_state == ST_POST);
      w_nxt_load_stb = (w_nxt_state == ST_LOAD);
   end

   // Outputs are registered from the next-state decode so pause is a clean flop level.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_ptr      <= '0;
         r_grant    <= '0;
         r_pause    <= 1'b0;
         r_load_stb <= 1'b0;
         r_ack      <= '0;
      end else begin
         r_state    <= w_nxt_state;
         r_cnt      <= w_nxt_cnt;
         r_ptr      <= w_nxt_ptr;
         r_grant    <= w_nxt_grant;
         r_pause    <= w_nxt_pause;
         r_load_stb <= w_nxt_load_stb;
         r_ack      <= w_nxt_ack;
      end
   end

   assign HS_IO_CLK_PAUSE = r_pause;
   assign LOAD_STB        = r_load_stb;
   assign LOAD_SEL        = r_grant;
   assign ACK             = r_ack;
   assign BUSY            = (r_state != ST_IDLE);

   a_load_pause : assert property (@(posedge CLK) disable iff (RESET) LOAD_STB |-> HS_IO_CLK_PAUSE);
   a_ack_nopause: assert property (@(posedge CLK) disable iff (RESET) (ACK != '0) |-> !HS_IO_CLK_PAUSE);
   a_ack_oh     : assert property (@(posedge CLK) disable iff (RESET) $onehot0(ACK));
   a_sel_oh     : assert property (@(posedge CLK) disable iff (RESET) $onehot0(LOAD_SEL));
   a_pause_busy : assert property (@(posedge CLK) disable iff (RESET) HS_IO_CLK_PAUSE |-> BUSY);

endmodule
